// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: IDLE/FETCH/DECODE/EXEC/MEM/WB/HALTED sequencing.
// Ports: CLK/nRST, instr/iHit/dHit/Equal in; datapath controls, strobes, status out.
module multicycle_control_unit #(
  parameter int OP_W       = 6,
  parameter int FUNC_W     = 6,
  parameter int ALUOP_W    = 4,
  parameter int WAIT_LIMIT = 255
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [31:0]        instr,
  input  logic               iHit,
  input  logic               dHit,
  input  logic               Equal,
  output logic               iMemRe,
  output logic               dMemRe,
  output logic               dMemWr,
  output logic               irWEN,
  output logic               pcWEN,
  output logic               regWEN,
  output logic               PcSrc,
  output logic               JReg,
  output logic               JType,
  output logic               RegDst,
  output logic [ALUOP_W-1:0] AluOp,
  output logic               AluSrc,
  output logic               ExtOp,
  output logic               MemToReg,
  output logic               UpperImm,
  output logic               RegZero,
  output logic               Halt,
  output logic               illegal,
  output logic               memTimeout,
  output logic [2:0]         state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALTED = 3'd6;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'('h00);
  localparam logic [OP_W-1:0] OP_J     = OP_W'('h02);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'('h03);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'('h04);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'('h05);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'('h08);
  localparam logic [OP_W-1:0] OP_ADDIU = OP_W'('h09);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'('h0a);
  localparam logic [OP_W-1:0] OP_SLTIU = OP_W'('h0b);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'('h0c);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'('h0d);
  localparam logic [OP_W-1:0] OP_XORI  = OP_W'('h0e);
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'('h0f);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'('h23);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'('h2b);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'('h3f);

  localparam logic [FUNC_W-1:0] FN_SLL  = FUNC_W'('h00);
  localparam logic [FUNC_W-1:0] FN_SRL  = FUNC_W'('h02);
  localparam logic [FUNC_W-1:0] FN_JR   = FUNC_W'('h08);
  localparam logic [FUNC_W-1:0] FN_ADD  = FUNC_W'('h20);
  localparam logic [FUNC_W-1:0] FN_ADDU = FUNC_W'('h21);
  localparam logic [FUNC_W-1:0] FN_SUB  = FUNC_W'('h22);
  localparam logic [FUNC_W-1:0] FN_SUBU = FUNC_W'('h23);
  localparam logic [FUNC_W-1:0] FN_AND  = FUNC_W'('h24);
  localparam logic [FUNC_W-1:0] FN_OR   = FUNC_W'('h25);
  localparam logic [FUNC_W-1:0] FN_XOR  = FUNC_W'('h26);
  localparam logic [FUNC_W-1:0] FN_NOR  = FUNC_W'('h27);
  localparam logic [FUNC_W-1:0] FN_SLT  = FUNC_W'('h2a);
  localparam logic [FUNC_W-1:0] FN_SLTU = FUNC_W'('h2b);

  localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_NOR  = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(9);

  localparam int CW = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

  logic [2:0]         r_state;
  logic [OP_W-1:0]    r_op;
  logic [FUNC_W-1:0]  r_func;
  logic [CW-1:0]      r_cnt;
  logic               r_halt;
  logic               r_illegal;
  logic               r_timeout;

  logic [2:0]         w_next;
  logic [CW-1:0]      w_cnt_nxt;
  logic [CW-1:0]      w_cnt_inc;
  logic               w_at_limit;
  logic               w_set_halt;
  logic               w_set_ill;
  logic               w_set_to;

  logic               w_legal;
  logic [ALUOP_W-1:0] w_aluop;
  logic               w_alusrc;
  logic               w_extop;
  logic               w_upper;
  logic               w_rzero;

  logic w_rtype;
  logic w_jr;
  logic w_j;
  logic w_jal;
  logic w_beq;
  logic w_bne;
  logic w_lw;
  logic w_sw;
  logic w_hlt;
  logic w_alu_en;
  logic w_unused_instr;

  assign w_unused_instr = ^instr[31-OP_W:FUNC_W];

  assign w_rtype = (r_op == OP_RTYPE);
  assign w_jr    = w_rtype && (r_func == FN_JR);
  assign w_j     = (r_op == OP_J);
  assign w_jal   = (r_op == OP_JAL);
  assign w_beq   = (r_op == OP_BEQ);
  assign w_bne   = (r_op == OP_BNE);
  assign w_lw    = (r_op == OP_LW);
  assign w_sw    = (r_op == OP_SW);
  assign w_hlt   = (r_op == OP_HALT);

  // Saturating wait counter; a miss that lands on LIMIT fires the watchdog.
  assign w_cnt_inc  = (r_cnt == LIMIT) ? r_cnt : r_cnt + CW'(1);
  assign w_at_limit = (w_cnt_inc == LIMIT);

  always_comb begin
    w_legal  = 1'b1;
    w_aluop  = ALU_ADD;
    w_alusrc = 1'b0;
    w_extop  = 1'b0;
    w_upper  = 1'b0;
    w_rzero  = 1'b0;
    unique case (r_op)
      OP_RTYPE: begin
        unique case (r_func)
          FN_SLL:  w_aluop = ALU_SLL;
          FN_SRL:  w_aluop = ALU_SRL;
          FN_JR:   w_aluop = ALU_ADD;
          FN_ADD,
          FN_ADDU: w_aluop = ALU_ADD;
          FN_SUB,
          FN_SUBU: w_aluop = ALU_SUB;
          FN_AND:  w_aluop = ALU_AND;
          FN_OR:   w_aluop = ALU_OR;
          FN_XOR:  w_aluop = ALU_XOR;
          FN_NOR:  w_aluop = ALU_NOR;
          FN_SLT:  w_aluop = ALU_SLT;
          FN_SLTU: w_aluop = ALU_SLTU;
          default: w_legal = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_HALT: ;
      OP_BEQ, OP_BNE: begin
        w_aluop = ALU_SUB;
        w_extop = 1'b1;
      end
      OP_ADDI, OP_ADDIU: begin
        w_alusrc = 1'b1;
        w_extop  = 1'b1;
      end
      OP_SLTI: begin
        w_aluop  = ALU_SLT;
        w_alusrc = 1'b1;
        w_extop  = 1'b1;
      end
      OP_SLTIU: begin
        w_aluop  = ALU_SLTU;
        w_alusrc = 1'b1;
        w_extop  = 1'b1;
      end
      OP_ANDI: begin
        w_aluop  = ALU_AND;
        w_alusrc = 1'b1;
      end
      OP_ORI: begin
        w_aluop  = ALU_OR;
        w_alusrc = 1'b1;
      end
      OP_XORI: begin
        w_aluop  = ALU_XOR;
        w_alusrc = 1'b1;
      end
      // LUI: rs forced to zero, shifted immediate added.
      OP_LUI: begin
        w_alusrc = 1'b1;
        w_upper  = 1'b1;
        w_rzero  = 1'b1;
      end
      OP_LW, OP_SW: begin
        w_alusrc = 1'b1;
        w_extop  = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_alu_en = (r_state == S_EXEC) ||
                    (r_state == S_MEM)  ||
                    (r_state == S_WB);

  always_comb begin
    w_next     = r_state;
    w_cnt_nxt  = '0;
    w_set_halt = 1'b0;
    w_set_ill  = 1'b0;
    w_set_to   = 1'b0;
    iMemRe     = 1'b0;
    dMemRe     = 1'b0;
    dMemWr     = 1'b0;
    irWEN      = 1'b0;
    pcWEN      = 1'b0;
    regWEN     = 1'b0;
    PcSrc      = 1'b0;
    JReg       = 1'b0;
    JType      = 1'b0;
    RegDst     = 1'b0;
    MemToReg   = 1'b0;
    unique case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        iMemRe = 1'b1;
        if (iHit) begin
          irWEN  = 1'b1;
          w_next = S_DECODE;
        end else if (w_at_limit) begin
          w_set_to   = 1'b1;
          w_set_halt = 1'b1;
          w_next     = S_HALTED;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_DECODE: begin
        if (w_hlt) begin
          w_set_halt = 1'b1;
          w_next     = S_HALTED;
        end else if (!w_legal) begin
          // Retire as a NOP so the PC still advances.
          w_set_ill = 1'b1;
          pcWEN     = 1'b1;
          w_next    = S_FETCH;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_beq || w_bne) begin
          PcSrc  = w_beq ? Equal : !Equal;
          pcWEN  = 1'b1;
          w_next = S_FETCH;
        end else if (w_j || w_jal) begin
          JType  = 1'b1;
          PcSrc  = 1'b1;
          JReg   = 1'b1;
          pcWEN  = 1'b1;
          regWEN = w_jal;
          w_next = S_FETCH;
        end else if (w_jr) begin
          JReg   = 1'b1;
          pcWEN  = 1'b1;
          w_next = S_FETCH;
        end else if (w_lw || w_sw) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        dMemRe = w_lw;
        dMemWr = w_sw;
        if (dHit) begin
          if (w_lw) begin
            w_next = S_WB;
          end else begin
            pcWEN  = 1'b1;
            w_next = S_FETCH;
          end
        end else if (w_at_limit) begin
          w_set_to   = 1'b1;
          w_set_halt = 1'b1;
          w_next     = S_HALTED;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_WB: begin
        regWEN   = 1'b1;
        pcWEN    = 1'b1;
        MemToReg = w_lw;
        RegDst   = w_rtype;
        w_next   = S_FETCH;
      end
      S_HALTED: w_next = S_HALTED;
      default:  w_next = S_IDLE;
    endcase
  end

  assign AluOp    = w_alu_en ? w_aluop : '0;
  assign AluSrc   = w_alu_en & w_alusrc;
  assign ExtOp    = w_alu_en & w_extop;
  assign UpperImm = w_alu_en & w_upper;
  assign RegZero  = w_alu_en & w_rzero;

  assign Halt       = r_halt;
  assign illegal    = r_illegal;
  assign memTimeout = r_timeout;
  assign state      = r_state;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_func    <= '0;
      r_cnt     <= '0;
      r_halt    <= 1'b0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (irWEN) begin
        r_op   <= instr[31 -: OP_W];
        r_func <= instr[FUNC_W-1:0];
      end
      if (w_set_halt) r_halt    <= 1'b1;
      if (w_set_ill)  r_illegal <= 1'b1;
      if (w_set_to)   r_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (WAIT_LIMIT=4).
// Drives per-cycle vectors on negedge, compares a packed control word.
module tb_multicycle_control_unit;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] instr = '0;
  logic        iHit = 1'b0;
  logic        dHit = 1'b0;
  logic        Equal = 1'b0;
  logic        iMemRe, dMemRe, dMemWr, irWEN, pcWEN, regWEN;
  logic        PcSrc, JReg, JType, RegDst, AluSrc, ExtOp;
  logic        MemToReg, UpperImm, RegZero, Halt, illegal, memTimeout;
  logic [3:0]  AluOp;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I_ADDI = {6'h08, 26'h0};
  localparam logic [31:0] I_ORI  = {6'h0d, 26'h0};
  localparam logic [31:0] I_SUB  = {6'h00, 20'h0, 6'h22};
  localparam logic [31:0] I_LW   = {6'h23, 26'h0};
  localparam logic [31:0] I_SW   = {6'h2b, 26'h0};
  localparam logic [31:0] I_BEQ  = {6'h04, 26'h0};
  localparam logic [31:0] I_BNE  = {6'h05, 26'h0};
  localparam logic [31:0] I_J    = {6'h02, 26'h0};
  localparam logic [31:0] I_JAL  = {6'h03, 26'h0};
  localparam logic [31:0] I_JR   = {6'h00, 20'h0, 6'h08};
  localparam logic [31:0] I_BAD  = {6'h3e, 26'h0};
  localparam logic [31:0] I_HALT = {6'h3f, 26'h0};

  // {state, iMemRe irWEN pcWEN regWEN, dMemRe dMemWr MemToReg, PcSrc JReg JType}
  logic [12:0] obs;
  assign obs = {state, iMemRe, irWEN, pcWEN, regWEN,
                dMemRe, dMemWr, MemToReg, PcSrc, JReg, JType};

  multicycle_control_unit #(.WAIT_LIMIT(4)) dut (
    .CLK(CLK), .nRST(nRST), .instr(instr), .iHit(iHit),
    .dHit(dHit), .Equal(Equal), .iMemRe(iMemRe),
    .dMemRe(dMemRe), .dMemWr(dMemWr), .irWEN(irWEN),
    .pcWEN(pcWEN), .regWEN(regWEN), .PcSrc(PcSrc),
    .JReg(JReg), .JType(JType), .RegDst(RegDst),
    .AluOp(AluOp), .AluSrc(AluSrc), .ExtOp(ExtOp),
    .MemToReg(MemToReg), .UpperImm(UpperImm),
    .RegZero(RegZero), .Halt(Halt), .illegal(illegal),
    .memTimeout(memTimeout), .state(state)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic apply_reset();
    nRST = 1'b0;
    cyc();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    #1;
    checks++;
    if (obs !== 13'd0 || AluOp !== 4'd0 || ExtOp !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs obs=%b alu=%0d ext=%b req=0", obs, AluOp, ExtOp);
    end
    checks++;
    if ({Halt, illegal, memTimeout} !== 3'b000) begin
      errors++;
      $display("FAIL reset_sticky got=%b req=000", {Halt, illegal, memTimeout});
    end
    cyc();
    nRST = 1'b1;
  endtask

  task automatic test_addi();
    logic [12:0] ex [0:4];
    ex = '{{3'd0, 10'b0000_000_000}, {3'd1, 10'b1100_000_000},
           {3'd2, 10'b0}, {3'd3, 10'b0}, {3'd5, 10'b0011_000_000}};
    instr = I_ADDI; iHit = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL addi c%0d got=%b req=%b", i, obs, ex[i]);
      end
      if (i == 3) begin
        checks++;
        if ({AluOp, AluSrc, ExtOp} !== {4'd2, 1'b1, 1'b1}) begin
          errors++;
          $display("FAIL addi_alu got=%0d/%b/%b req=2/1/1", AluOp, AluSrc, ExtOp);
        end
      end
      cyc();
    end
  endtask

  task automatic test_lw();
    logic [12:0] ex [0:7];
    logic dh [0:7];
    ex = '{{3'd1, 10'b1100_000_000}, {3'd2, 10'b0}, {3'd3, 10'b0},
           {3'd4, 10'b0000_100_000}, {3'd4, 10'b0000_100_000},
           {3'd4, 10'b0000_100_000}, {3'd4, 10'b0000_100_000},
           {3'd5, 10'b0011_001_000}};
    dh = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    instr = I_LW; iHit = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dHit = dh[i];
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL lw c%0d got=%b req=%b", i, obs, ex[i]);
      end
      cyc();
    end
    dHit = 1'b0;
    checks++;
    if (state !== 3'd1 || memTimeout !== 1'b0) begin
      errors++;
      $display("FAIL lw_after state=%0d to=%b req=1/0", state, memTimeout);
    end
  endtask

  task automatic test_branch();
    logic [12:0] ex [0:5];
    logic [31:0] ins [0:5];
    ex = '{{3'd1, 10'b1100_000_000}, {3'd2, 10'b0},
           {3'd3, 10'b0010_000_100},
           {3'd1, 10'b1100_000_000}, {3'd2, 10'b0},
           {3'd3, 10'b0010_000_000}};
    ins = '{I_BEQ, I_BEQ, I_BEQ, I_BNE, I_BNE, I_BNE};
    Equal = 1'b1; iHit = 1'b1;
    for (int i = 0; i < 6; i++) begin
      instr = ins[i];
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL branch c%0d got=%b req=%b", i, obs, ex[i]);
      end
      if (i == 2) begin
        checks++;
        if ({AluOp, AluSrc} !== {4'd3, 1'b0}) begin
          errors++;
          $display("FAIL beq_alu got=%0d/%b req=3/0", AluOp, AluSrc);
        end
      end
      cyc();
    end
    Equal = 1'b0;
  endtask

  task automatic test_jumps();
    logic [12:0] ex [0:8];
    logic [31:0] ins [0:8];
    ex = '{{3'd1, 10'b1100_000_000}, {3'd2, 10'b0},
           {3'd3, 10'b0010_000_111},
           {3'd1, 10'b1100_000_000}, {3'd2, 10'b0},
           {3'd3, 10'b0011_000_111},
           {3'd1, 10'b1100_000_000}, {3'd2, 10'b0},
           {3'd3, 10'b0010_000_010}};
    ins = '{I_J, I_J, I_J, I_JAL, I_JAL, I_JAL, I_JR, I_JR, I_JR};
    iHit = 1'b1;
    for (int i = 0; i < 9; i++) begin
      instr = ins[i];
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL jump c%0d got=%b req=%b", i, obs, ex[i]);
      end
      cyc();
    end
  endtask

  task automatic test_alu_ops();
    logic [12:0] ex [0:7];
    logic [31:0] ins [0:7];
    ex = '{{3'd1, 10'b1100_000_000}, {3'd2, 10'b0}, {3'd3, 10'b0},
           {3'd5, 10'b0011_000_000},
           {3'd1, 10'b1100_000_000}, {3'd2, 10'b0}, {3'd3, 10'b0},
           {3'd5, 10'b0011_000_000}};
    ins = '{I_ORI, I_ORI, I_ORI, I_ORI, I_SUB, I_SUB, I_SUB, I_SUB};
    iHit = 1'b1;
    for (int i = 0; i < 8; i++) begin
      instr = ins[i];
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL aluops c%0d got=%b req=%b", i, obs, ex[i]);
      end
      if (i == 3) begin
        checks++;
        if ({AluOp, AluSrc, ExtOp, RegDst} !== {4'd5, 3'b100}) begin
          errors++;
          $display("FAIL ori_ctl got=%0d/%b%b%b req=5/100",
                   AluOp, AluSrc, ExtOp, RegDst);
        end
      end
      if (i == 7) begin
        checks++;
        if ({AluOp, AluSrc, RegDst} !== {4'd3, 2'b01}) begin
          errors++;
          $display("FAIL sub_ctl got=%0d/%b%b req=3/01", AluOp, AluSrc, RegDst);
        end
      end
      cyc();
    end
  endtask

  task automatic test_illegal();
    logic [12:0] ex [0:5];
    logic [31:0] ins [0:5];
    ex = '{{3'd1, 10'b1100_000_000}, {3'd2, 10'b0010_000_000},
           {3'd1, 10'b1100_000_000}, {3'd2, 10'b0}, {3'd3, 10'b0},
           {3'd5, 10'b0011_000_000}};
    ins = '{I_BAD, I_BAD, I_ADDI, I_ADDI, I_ADDI, I_ADDI};
    iHit = 1'b1;
    for (int i = 0; i < 6; i++) begin
      instr = ins[i];
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL illegal c%0d got=%b req=%b", i, obs, ex[i]);
      end
      if (i == 2) begin
        checks++;
        if (illegal !== 1'b1) begin
          errors++;
          $display("FAIL illegal_set got=%b req=1", illegal);
        end
      end
      cyc();
    end
    checks++;
    if (illegal !== 1'b1 || Halt !== 1'b0) begin
      errors++;
      $display("FAIL illegal_sticky got=%b halt=%b req=1/0", illegal, Halt);
    end
  endtask

  task automatic test_sw_reset();
    logic [12:0] ex [0:3];
    ex = '{{3'd1, 10'b1100_000_000}, {3'd2, 10'b0}, {3'd3, 10'b0},
           {3'd4, 10'b0000_010_000}};
    instr = I_SW; iHit = 1'b1; dHit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL sw c%0d got=%b req=%b", i, obs, ex[i]);
      end
      if (i < 3) cyc();
    end
    nRST = 1'b0;
    #1;
    checks++;
    if (obs !== 13'd0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL sw_abort got=%b ill=%b req=0/0", obs, illegal);
    end
    cyc();
    nRST = 1'b1;
    #1;
    checks++;
    if (obs !== 13'd0) begin
      errors++;
      $display("FAIL sw_release got=%b req=0", obs);
    end
    cyc();
    checks++;
    if (obs !== {3'd1, 10'b1100_000_000}) begin
      errors++;
      $display("FAIL sw_refetch got=%b req=%b", obs, {3'd1, 10'b1100_000_000});
    end
  endtask

  task automatic test_hit_at_limit();
    logic [12:0] ex [0:7];
    logic ih [0:7];
    ex = '{{3'd0, 10'b0}, {3'd1, 10'b1000_000_000},
           {3'd1, 10'b1000_000_000}, {3'd1, 10'b1000_000_000},
           {3'd1, 10'b1100_000_000}, {3'd2, 10'b0},
           {3'd6, 10'b0}, {3'd6, 10'b0}};
    ih = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    apply_reset();
    instr = I_HALT;
    for (int i = 0; i < 8; i++) begin
      iHit = ih[i];
      #1;
      checks++;
      if (obs !== ex[i] || memTimeout !== 1'b0) begin
        errors++;
        $display("FAIL hitlim c%0d got=%b to=%b req=%b/0",
                 i, obs, memTimeout, ex[i]);
      end
      cyc();
    end
    checks++;
    if (Halt !== 1'b1 || state !== 3'd6) begin
      errors++;
      $display("FAIL halt got=%b st=%0d req=1/6", Halt, state);
    end
  endtask

  task automatic test_timeout();
    logic [12:0] ex [0:7];
    ex = '{{3'd0, 10'b0}, {3'd1, 10'b1000_000_000},
           {3'd1, 10'b1000_000_000}, {3'd1, 10'b1000_000_000},
           {3'd1, 10'b1000_000_000}, {3'd6, 10'b0},
           {3'd6, 10'b0}, {3'd6, 10'b0}};
    apply_reset();
    instr = I_ADDI; iHit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL timeout c%0d got=%b req=%b", i, obs, ex[i]);
      end
      checks++;
      if ({memTimeout, Halt} !== ((i >= 5) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL timeout_flags c%0d got=%b req=%b",
                 i, {memTimeout, Halt}, (i >= 5) ? 2'b11 : 2'b00);
      end
      cyc();
    end
    iHit = 1'b1;
    cyc();
    checks++;
    if (state !== 3'd6) begin
      errors++;
      $display("FAIL timeout_hold state=%0d req=6", state);
    end
    apply_reset();
    #1;
    checks++;
    if ({state, Halt, memTimeout} !== 5'd0) begin
      errors++;
      $display("FAIL timeout_clear got=%b req=0", {state, Halt, memTimeout});
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_addi();
    test_lw();
    test_branch();
    test_jumps();
    test_alu_ops();
    test_illegal();
    test_sw_reset();
    test_hit_at_limit();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
